// File: rtl/cpu_ctrl_if.sv
// Instruction and data memory handshake bundle for cpu_ctrl_fsm.
// Both ports are req/ack: the request is held until the matching ack is sampled.
interface cpu_ctrl_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [7:0]      imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit CPU: fetch, decode, execute, memory, writeback.
// Optional performance counters (cyc_cnt, instr_cnt) are built when CTRL_PERF_CNT_EN is defined.
module cpu_ctrl_fsm #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   cpu_ctrl_if.master      bus,
   output logic [1:0]      rs_addr,
   output logic [1:0]      rt_addr,
   output logic [1:0]      rd_addr,
   output logic [7:0]      imm,
   output logic            alusrc,
   output logic            reg_we,
   output logic            mem_to_reg,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            retired
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0]     cyc_cnt,
   output logic [15:0]     instr_cnt
`endif
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_J   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_DONE
   } state_t;

   state_t     state;
   logic [7:0] ir;
   logic [1:0] op;
   logic [1:0] f_op;

   function automatic logic [7:0] sext_imm2(input logic [1:0] f);
      return {{6{f[1]}}, f};
   endfunction

   function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] p,
                                                   input logic [5:0]      off);
      logic signed [PC_W-1:0] soff;
      soff = {{(PC_W-6){off[5]}}, off};
      return p + PC_W'(1) + PC_W'(soff);
   endfunction

   assign op            = ir[7:6];
   assign f_op          = bus.imem_rdata[7:6];
   assign bus.imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ir           <= '0;
         pc           <= '0;
         rs_addr      <= '0;
         rt_addr      <= '0;
         rd_addr      <= '0;
         imm          <= '0;
         alusrc       <= 1'b0;
         mem_to_reg   <= 1'b0;
         reg_we       <= 1'b0;
         retired      <= 1'b0;
         busy         <= 1'b0;
         bus.imem_req <= 1'b0;
         bus.dmem_req <= 1'b0;
         bus.dmem_we  <= 1'b0;
      end else begin
         reg_we  <= 1'b0;
         retired <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_FETCH;
                  bus.imem_req <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            S_FETCH: begin
               // Decode fields are registered with IR so they hold until the next fetch completes.
               if (bus.imem_ack) begin
                  state        <= S_DECODE;
                  bus.imem_req <= 1'b0;
                  ir           <= bus.imem_rdata;
                  rs_addr      <= bus.imem_rdata[5:4];
                  rt_addr      <= bus.imem_rdata[3:2];
                  // LW writes its result to rt, so the write select follows rt for loads.
                  rd_addr      <= (f_op == OP_LW) ? bus.imem_rdata[3:2] : bus.imem_rdata[1:0];
                  imm          <= (f_op == OP_LW || f_op == OP_SW) ?
                                  sext_imm2(bus.imem_rdata[1:0]) : 8'h00;
                  alusrc       <= (f_op == OP_LW || f_op == OP_SW);
                  mem_to_reg   <= (f_op == OP_LW);
               end
            end
            S_DECODE: begin
               if (op == OP_J) begin
                  state   <= S_DONE;
                  pc      <= jump_target(pc, ir[5:0]);
                  retired <= 1'b1;
               end else begin
                  state <= S_EXEC;
                  pc    <= pc + PC_W'(1);
               end
            end
            S_EXEC: begin
               if (op == OP_ADD) begin
                  state  <= S_WB;
                  reg_we <= 1'b1;
               end else begin
                  state        <= S_MEM;
                  bus.dmem_req <= 1'b1;
                  bus.dmem_we  <= (op == OP_SW);
               end
            end
            S_MEM: begin
               if (bus.dmem_ack) begin
                  bus.dmem_req <= 1'b0;
                  bus.dmem_we  <= 1'b0;
                  if (op == OP_SW) begin
                     state   <= S_DONE;
                     retired <= 1'b1;
                  end else begin
                     state  <= S_WB;
                     reg_we <= 1'b1;
                  end
               end
            end
            S_WB: begin
               state   <= S_DONE;
               retired <= 1'b1;
            end
            S_DONE: begin
               if (start) begin
                  state        <= S_FETCH;
                  bus.imem_req <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt   <= '0;
         instr_cnt <= '0;
      end else begin
         if (busy)    cyc_cnt   <= sat_inc16(cyc_cnt);
         if (retired) instr_cnt <= sat_inc16(instr_cnt);
      end
   end
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed instructions, memory responders with programmable waits.
module tb_cpu_ctrl_fsm;

   typedef struct {
      string      name;
      logic [7:0] pc;
      logic       chk_regs;
      logic [1:0] rs;
      logic [1:0] rt;
      logic [1:0] rd;
      logic [7:0] imm;
      logic       alusrc;
      logic       m2r;
      int         cycles;
      int         regwe_at;
      int         dreq_cnt;
      logic       dwe;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] rs_addr, rt_addr, rd_addr;
   logic [7:0] imm;
   logic       alusrc, reg_we, mem_to_reg;
   logic [7:0] pc;
   logic       busy, retired;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0] cyc_cnt, instr_cnt;
`endif

   cpu_ctrl_if #(.PC_W(8)) bus ();

   cpu_ctrl_fsm #(.PC_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rd_addr    (rd_addr),
      .imm        (imm),
      .alusrc     (alusrc),
      .reg_we     (reg_we),
      .mem_to_reg (mem_to_reg),
      .pc         (pc),
      .busy       (busy),
      .retired    (retired)
`ifdef CTRL_PERF_CNT_EN
      ,
      .cyc_cnt    (cyc_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   logic [7:0] prog [256];
   int         imem_wait = 0;
   int         dmem_wait = 0;
   int         icnt = 0;
   int         dcnt = 0;

   int         mon_icyc = 0;
   int         mon_regwe_at = 0;
   int         mon_regwe_cnt = 0;
   int         mon_dreq_cnt = 0;
   logic       mon_dwe = 1'b0;
   logic       mon_prev_req = 1'b0;
   exp_t       mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Memory responders: ack after the programmed number of wait cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = 8'h00;
         bus.dmem_ack   = 1'b0;
         icnt = 0;
         dcnt = 0;
      end else begin
         if (bus.imem_req) begin
            if (icnt == imem_wait) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = prog[bus.imem_addr];
            end else begin
               bus.imem_ack = 1'b0;
               icnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            icnt = 0;
         end
         if (bus.dmem_req) begin
            if (dcnt == dmem_wait) begin
               bus.dmem_ack = 1'b1;
            end else begin
               bus.dmem_ack = 1'b0;
               dcnt++;
            end
         end else begin
            bus.dmem_ack = 1'b0;
            dcnt = 0;
         end
      end
   end

   // Monitor: tracks per-instruction activity from FETCH entry and scores it on retire.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_icyc     = 0;
         mon_prev_req = 1'b0;
      end else begin
         if (bus.imem_req && !mon_prev_req) begin
            mon_icyc      = 1;
            mon_regwe_at  = 0;
            mon_regwe_cnt = 0;
            mon_dreq_cnt  = 0;
            mon_dwe       = 1'b0;
         end else if (mon_icyc != 0) begin
            mon_icyc++;
         end
         if (reg_we) begin
            mon_regwe_cnt++;
            if (mon_regwe_at == 0) mon_regwe_at = mon_icyc;
         end
         if (bus.dmem_req) begin
            mon_dreq_cnt++;
            mon_dwe = bus.dmem_we;
         end
         if (retired) begin
            if (exp_q.size() == 0) begin
               check("unexpected_retire", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check({mon_e.name, "_cycles"}, mon_icyc, mon_e.cycles);
               check({mon_e.name, "_pc"}, pc, mon_e.pc);
               check({mon_e.name, "_regwe_at"}, mon_regwe_at, mon_e.regwe_at);
               check({mon_e.name, "_regwe_cnt"}, mon_regwe_cnt, (mon_e.regwe_at != 0) ? 1 : 0);
               check({mon_e.name, "_dreq_cnt"}, mon_dreq_cnt, mon_e.dreq_cnt);
               if (mon_e.dreq_cnt != 0) check({mon_e.name, "_dmem_we"}, mon_dwe, mon_e.dwe);
               check({mon_e.name, "_imm"}, imm, mon_e.imm);
               check({mon_e.name, "_alusrc"}, alusrc, mon_e.alusrc);
               check({mon_e.name, "_mem_to_reg"}, mem_to_reg, mon_e.m2r);
               if (mon_e.chk_regs) begin
                  check({mon_e.name, "_rs"}, rs_addr, mon_e.rs);
                  check({mon_e.name, "_rt"}, rt_addr, mon_e.rt);
                  check({mon_e.name, "_rd"}, rd_addr, mon_e.rd);
               end
            end
         end
         mon_prev_req = bus.imem_req;
      end
   end

   task automatic push(input string name, input logic [7:0] epc, input logic chk_regs,
                       input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                       input logic [7:0] eimm, input logic ealusrc, input logic em2r,
                       input int cycles, input int regwe_at, input int dreq_cnt, input logic dwe);
      exp_t e;
      e.name = name;  e.pc = epc;  e.chk_regs = chk_regs;
      e.rs = rs;  e.rt = rt;  e.rd = rd;
      e.imm = eimm;  e.alusrc = ealusrc;  e.m2r = em2r;
      e.cycles = cycles;  e.regwe_at = regwe_at;  e.dreq_cnt = dreq_cnt;  e.dwe = dwe;
      exp_q.push_back(e);
   endtask

   task automatic run_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, busy, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = 8'h00;
      rst_n = 1'b0;
      start = 1'b0;
      #12;
      check("rst_pc", pc, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_imem_req", bus.imem_req, 1'b0);
      check("rst_dmem_req", bus.dmem_req, 1'b0);
      check("rst_reg_we", reg_we, 1'b0);
      check("rst_retired", retired, 1'b0);
      check("rst_imm", imm, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_fetch", bus.imem_req, 1'b0);

      // ADD r3 = r1 + r2 at pc 0
      prog[0] = 8'b00_01_10_11;
      push("add", 8'd1, 1'b1, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0, 1'b0, 5, 4, 0, 1'b0);
      run_pulse();
      wait_idle("add");

      // LW r1 = mem[r0 - 1], three dmem wait cycles
      prog[1] = 8'b01_00_01_11;
      dmem_wait = 3;
      push("lw", 8'd2, 1'b1, 2'd0, 2'd1, 2'd1, 8'hFF, 1'b1, 1'b1, 9, 8, 4, 1'b0);
      run_pulse();
      wait_idle("lw");
      dmem_wait = 0;

      // SW mem[r2 + 1] = r3
      prog[2] = 8'b10_10_11_01;
      push("sw", 8'd3, 1'b1, 2'd2, 2'd3, 2'd1, 8'h01, 1'b1, 1'b0, 5, 0, 1, 1'b1);
      run_pulse();
      wait_idle("sw");

      // Jumps: 3 -> 5 (two imem waits), 5 -> 4, 4 -> FE, FE -> 02 across the wrap
      prog[3]     = 8'b11_000001;
      prog[5]     = 8'b11_111110;
      prog[4]     = 8'b11_111001;
      prog[8'hFE] = 8'b11_000011;
      imem_wait = 2;
      push("j_wait", 8'd5, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 5, 0, 0, 1'b0);
      run_pulse();
      wait_idle("j_wait");
      imem_wait = 0;
      push("j_back", 8'd4, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3, 0, 0, 1'b0);
      run_pulse();
      wait_idle("j_back");
      push("j_to_fe", 8'hFE, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3, 0, 0, 1'b0);
      run_pulse();
      wait_idle("j_to_fe");
      push("j_wrap", 8'h02, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3, 0, 0, 1'b0);
      run_pulse();
      wait_idle("j_wrap");

      // ADD at pc 2 with start dropped while in EXEC
      prog[2] = 8'b00_11_00_10;
      push("add_stop", 8'd3, 1'b1, 2'd3, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0, 5, 4, 0, 1'b0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle("add_stop");
      repeat (2) @(negedge clk);
      check("stop_stays_idle", bus.imem_req, 1'b0);

      // Reset while waiting in MEM
      prog[3] = 8'b01_00_01_11;
      dmem_wait = 100;
      run_pulse();
      for (int n = 0; n < 20 && !bus.dmem_req; n++) @(negedge clk);
      check("mem_reached", bus.dmem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mrst_dmem_req", bus.dmem_req, 1'b0);
      check("mrst_pc", pc, 8'h00);
      check("mrst_busy", busy, 1'b0);
      check("mrst_imem_req", bus.imem_req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_wait = 0;
      @(negedge clk);

      // Three back-to-back zero-wait ADDs from pc 0
      prog[0] = 8'b00_01_10_11;
      prog[1] = 8'b00_00_01_10;
      prog[2] = 8'b00_11_10_01;
      push("b2b0", 8'd1, 1'b1, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0, 1'b0, 5, 4, 0, 1'b0);
      push("b2b1", 8'd2, 1'b1, 2'd0, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0, 5, 4, 0, 1'b0);
      push("b2b2", 8'd3, 1'b1, 2'd3, 2'd2, 2'd1, 8'h00, 1'b0, 1'b0, 5, 4, 0, 1'b0);
      start = 1'b1;
      repeat (12) @(negedge clk);
      start = 1'b0;
      wait_idle("b2b");
`ifdef CTRL_PERF_CNT_EN
      check("instr_cnt", instr_cnt, 16'd3);
      check("cyc_cnt", cyc_cnt, 16'd15);
`endif
      check("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
